// File: rtl/auv_pkg.sv
// Shared types and helpers for the CSR bus initiator.
//   csr_op_e          CSR operation as carried in funct3[1:0]
//   csr_init_state_e  initiator FSM states
//   CSR_RO_BITS       addr[11:10] pattern marking read-only CSRs
//   CSR_TIMEOUT       default strobe-without-ack abort limit
//   csr_rmw()         new CSR value from operation, old value and operand
package auv_pkg;

  typedef enum logic [1:0] {
    CSR_ILL = 2'b00,
    CSR_W   = 2'b01,
    CSR_S   = 2'b10,
    CSR_C   = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_RTURN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } csr_init_state_e;

  localparam logic [1:0] CSR_RO_BITS = 2'b11;
  localparam int         CSR_TIMEOUT = 16;

  function automatic logic [31:0] csr_rmw(csr_op_e op, logic [31:0] old, logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_W:   res = wdata;
      CSR_S:   res = old | wdata;
      CSR_C:   res = old & ~wdata;
      default: res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/auv_csr_initiator.sv
// CSR bus initiator: takes one CSR instruction from execute, performs the
// bus read and/or read-modify-write, returns the old value or an error.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_op/addr/wdata           operation, CSR address, operand
//   req_rd_en/req_wr_en         old value needed / write intended
//   resp_valid/rdata/err        one-cycle response pulse
//   busy                        ~req_ready
//   cbus_sel/rd/wr/adr/dat_wr   bus strobes, address, write data
//   cbus_dat_rd/cbus_ack        responder read data and acknowledge
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request
// ST_READ  | read strobe held until ack or timeout
// ST_RTURN | strobes low for one cycle; stale ack discarded
// ST_WRITE | write strobe held until ack or timeout
// ST_DONE  | response pulse cycle; stale ack discarded
module auv_csr_initiator
  import auv_pkg::*;
#(
  parameter int TIMEOUT = CSR_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_rd_en,
  input  logic        req_wr_en,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        cbus_sel,
  output logic        cbus_rd,
  output logic        cbus_wr,
  output logic [11:0] cbus_adr,
  output logic [31:0] cbus_dat_wr,
  input  logic [31:0] cbus_dat_rd,
  input  logic        cbus_ack
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  csr_init_state_e state;
  csr_op_e         op_q;
  logic [31:0]     wdata_q;
  logic            need_wr_q;
  logic [TW-1:0]   tmr;

  logic acc_need_rd;
  logic acc_illegal;

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;

  // S/C with a write must read first to form the new value; W never needs to.
  assign acc_need_rd = req_rd_en | (req_wr_en & (req_op != CSR_W));
  assign acc_illegal = (req_op == CSR_ILL) | (req_wr_en & (req_addr[11:10] == CSR_RO_BITS));

  // The abort timer counts down from TIMEOUT-1; reaching zero without an ack
  // means the strobe has been held TIMEOUT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_q        <= CSR_ILL;
      wdata_q     <= '0;
      need_wr_q   <= 1'b0;
      tmr         <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      cbus_sel    <= 1'b0;
      cbus_rd     <= 1'b0;
      cbus_wr     <= 1'b0;
      cbus_adr    <= '0;
      cbus_dat_wr <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cbus_adr   <= req_addr;
            op_q       <= csr_op_e'(req_op);
            wdata_q    <= req_wdata;
            need_wr_q  <= req_wr_en;
            tmr        <= TMR_LOAD;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (acc_illegal) begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (acc_need_rd) begin
              state    <= ST_READ;
              cbus_sel <= 1'b1;
              cbus_rd  <= 1'b1;
            end else if (req_wr_en) begin
              state       <= ST_WRITE;
              cbus_sel    <= 1'b1;
              cbus_wr     <= 1'b1;
              cbus_dat_wr <= req_wdata;
            end else begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
            end
          end
        end

        ST_READ: begin
          if (cbus_ack) begin
            cbus_sel    <= 1'b0;
            cbus_rd     <= 1'b0;
            resp_rdata  <= cbus_dat_rd;
            // Merge here so write data is already stable through RTURN.
            cbus_dat_wr <= csr_rmw(op_q, cbus_dat_rd, wdata_q);
            if (need_wr_q) begin
              state <= ST_RTURN;
            end else begin
              state      <= ST_DONE;
              resp_valid <= 1'b1;
            end
          end else if (tmr == '0) begin
            cbus_sel   <= 1'b0;
            cbus_rd    <= 1'b0;
            state      <= ST_DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        ST_RTURN: begin
          state    <= ST_WRITE;
          cbus_sel <= 1'b1;
          cbus_wr  <= 1'b1;
          tmr      <= TMR_LOAD;
        end

        ST_WRITE: begin
          if (cbus_ack) begin
            cbus_sel   <= 1'b0;
            cbus_wr    <= 1'b0;
            state      <= ST_DONE;
            resp_valid <= 1'b1;
          end else if (tmr == '0) begin
            cbus_sel   <= 1'b0;
            cbus_wr    <= 1'b0;
            state      <= ST_DONE;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          cbus_sel <= 1'b0;
          cbus_rd  <= 1'b0;
          cbus_wr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_auv_csr_initiator.sv
module tb_auv_csr_initiator;
  import auv_pkg::*;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_rd_en = 1'b0;
  logic        req_wr_en = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        cbus_sel, cbus_rd, cbus_wr;
  logic [11:0] cbus_adr;
  logic [31:0] cbus_dat_wr;
  bit   [31:0] cbus_dat_rd;
  bit          cbus_ack;

  always #5 clk = ~clk;

  auv_csr_initiator #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy),
    .cbus_sel(cbus_sel), .cbus_rd(cbus_rd), .cbus_wr(cbus_wr),
    .cbus_adr(cbus_adr), .cbus_dat_wr(cbus_dat_wr),
    .cbus_dat_rd(cbus_dat_rd), .cbus_ack(cbus_ack)
  );

  // Registered responder: acks once the strobe has been seen for lat_cfg+1
  // edges, and keeps re-acking while the strobe stays high.
  bit [31:0] mem [4096];
  bit        pre_en = 1'b0;
  bit [11:0] pre_adr = '0;
  bit [31:0] pre_val = '0;
  int        lat_cfg = 0;
  bit        noack = 1'b0;
  int        rsp_cnt = 0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_adr] <= pre_val;
    if (cbus_sel && (cbus_rd || cbus_wr)) begin
      if (!noack && rsp_cnt >= lat_cfg) begin
        cbus_ack    <= 1'b1;
        cbus_dat_rd <= mem[cbus_adr];
        if (cbus_wr) mem[cbus_adr] <= cbus_dat_wr;
      end else begin
        cbus_ack <= 1'b0;
      end
      rsp_cnt <= rsp_cnt + 1;
    end else begin
      cbus_ack <= 1'b0;
      rsp_cnt  <= 0;
    end
  end

  // Bus monitor (free-running counters, differenced per request).
  int          rd_rises = 0, wr_rises = 0, sel_cycles = 0, sel_bad = 0, resp_pulses = 0;
  logic        rd_q = 1'b0, wr_q = 1'b0;
  logic [31:0] last_wdat = '0;

  always @(negedge clk) begin
    rd_q <= cbus_rd;
    wr_q <= cbus_wr;
    if (cbus_rd === 1'b1 && rd_q !== 1'b1) rd_rises <= rd_rises + 1;
    if (cbus_wr === 1'b1 && wr_q !== 1'b1) wr_rises <= wr_rises + 1;
    if (cbus_sel === 1'b1) sel_cycles <= sel_cycles + 1;
    if (cbus_sel !== (cbus_rd | cbus_wr)) sel_bad <= sel_bad + 1;
    if (cbus_wr === 1'b1) last_wdat <= cbus_dat_wr;
    if (resp_valid === 1'b1) resp_pulses <= resp_pulses + 1;
  end

  int        vectors = 0;
  int        miscompares = 0;
  bit [31:0] model_mem [4096];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preset(logic [11:0] a, logic [31:0] v);
    @(negedge clk);
    pre_adr = a; pre_val = v; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
    model_mem[a] = v;
  endtask

  // Issues one request and checks it against the reference model.
  task automatic do_req(string tag, logic [1:0] op, logic [11:0] addr, logic [31:0] wd,
                        logic rd_en, logic wr_en);
    logic [31:0] old, e_rdata, e_new, e_wdat;
    logic        e_err, need_rd, need_wr, ill;
    int          e_lat, e_nrd, e_nwr, e_sel;
    int          b_rd, b_wr, b_sel, b_bad, b_resp;
    int          lat;
    logic        got;
    logic [31:0] o_rdata;
    logic        o_err;

    old     = model_mem[addr];
    need_rd = rd_en | (wr_en & (op != 2'b01));
    need_wr = wr_en;
    ill     = (op == 2'b00) || (wr_en && addr >= 12'hC00);
    e_err = 0; e_rdata = 0; e_new = old; e_wdat = 0;
    e_lat = 0; e_nrd = 0; e_nwr = 0; e_sel = 0;
    if (ill) begin
      e_err = 1;
    end else if (need_rd || need_wr) begin
      if (noack) begin
        e_err = 1; e_lat = TO; e_sel = TO;
        e_nrd = need_rd ? 1 : 0;
        e_nwr = need_rd ? 0 : 1;
      end else begin
        e_rdata = need_rd ? old : 32'h0;
        if (need_wr) begin
          case (op)
            2'b01:   e_new = wd;
            2'b10:   e_new = old | wd;
            default: e_new = old & ~wd;
          endcase
          e_wdat = e_new;
        end
        e_nrd = need_rd ? 1 : 0;
        e_nwr = need_wr ? 1 : 0;
        e_sel = (need_rd ? lat_cfg + 2 : 0) + (need_wr ? lat_cfg + 2 : 0);
        e_lat = (need_rd && need_wr) ? 2 * lat_cfg + 5 : lat_cfg + 2;
      end
    end

    @(negedge clk);
    b_rd = rd_rises; b_wr = wr_rises; b_sel = sel_cycles; b_bad = sel_bad; b_resp = resp_pulses;
    check({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    req_rd_en = rd_en; req_wr_en = wr_en;
    @(posedge clk); #1;
    // Garbage while busy must be ignored.
    req_op = 2'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
    req_rd_en = 1'($urandom); req_wr_en = 1'($urandom);
    got = 0; lat = 0;
    if (resp_valid === 1'b1) got = 1;
    else begin
      for (int k = 1; k <= 200; k++) begin
        @(posedge clk); #1;
        if (resp_valid === 1'b1) begin got = 1; lat = k; break; end
      end
    end
    req_valid = 1'b0;
    o_rdata = resp_rdata; o_err = resp_err;
    check({tag, ".resp_seen"}, got, 1);
    check({tag, ".latency"}, lat, e_lat);
    check({tag, ".rdata"}, o_rdata, e_rdata);
    check({tag, ".err"}, o_err, e_err);
    @(posedge clk); #1;
    check({tag, ".pulse_end"}, resp_valid, 0);
    check({tag, ".ready_after"}, req_ready, 1);
    @(negedge clk);
    check({tag, ".n_read"}, rd_rises - b_rd, e_nrd);
    check({tag, ".n_write"}, wr_rises - b_wr, e_nwr);
    check({tag, ".sel_cycles"}, sel_cycles - b_sel, e_sel);
    check({tag, ".sel_strobe"}, sel_bad - b_bad, 0);
    check({tag, ".n_resp"}, resp_pulses - b_resp, 1);
    if (e_nwr > 0 && !noack) check({tag, ".dat_wr"}, last_wdat, e_wdat);
    check({tag, ".mem"}, mem[addr], e_new);
    model_mem[addr] = e_new;
  endtask

  logic [11:0] addrs [8];

  initial begin
    int b_resp;
    addrs = '{12'h340, 12'h341, 12'h300, 12'h305, 12'hF11, 12'hC00, 12'h7FF, 12'hBFF};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.ready", req_ready, 1);
    check("reset.busy", busy, 0);
    check("reset.resp_valid", resp_valid, 0);
    check("reset.rdata", resp_rdata, 0);
    check("reset.err", resp_err, 0);
    check("reset.strobes", {cbus_sel, cbus_rd, cbus_wr}, 0);
    check("reset.adr", cbus_adr, 0);
    check("reset.dat_wr", cbus_dat_wr, 0);

    lat_cfg = 0; noack = 0;
    preset(12'h340, 32'h0000_00F0);
    do_req("rmw_s", 2'b10, 12'h340, 32'h0F, 1, 1);
    preset(12'h340, 32'h0000_00FF);
    do_req("rmw_c", 2'b11, 12'h340, 32'h0F, 1, 1);
    do_req("w_only", 2'b01, 12'h340, 32'h1234_5678, 0, 1);
    do_req("ro_read", 2'b10, 12'hF11, 32'h0, 1, 0);
    do_req("ro_write", 2'b10, 12'hF11, 32'h5, 1, 1);
    do_req("illegal", 2'b00, 12'h300, 32'h5, 1, 1);
    do_req("no_access", 2'b10, 12'h300, 32'h0, 0, 0);
    lat_cfg = 2;
    do_req("rmw_lat2", 2'b01, 12'h305, 32'hA5A5_0000, 1, 1);

    noack = 1; lat_cfg = 0;
    do_req("tmo_rmw", 2'b10, 12'h340, 32'hF, 1, 1);
    do_req("tmo_wr", 2'b01, 12'h341, 32'h77, 0, 1);
    noack = 0;

    // Reset while the write strobe is held.
    lat_cfg = 3;
    preset(12'h305, 32'hCAFE_0001);
    b_resp = resp_pulses;
    @(negedge clk);
    req_valid = 1; req_op = 2'b01; req_addr = 12'h305; req_wdata = 32'hDEAD_BEEF;
    req_rd_en = 0; req_wr_en = 1;
    @(posedge clk); #1;
    req_valid = 0;
    check("rst_mid.busy", busy, 1);
    check("rst_mid.wr_high", cbus_wr, 1);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid.strobes", {cbus_sel, cbus_rd, cbus_wr}, 0);
    check("rst_mid.ready", req_ready, 1);
    check("rst_mid.adr", cbus_adr, 0);
    check("rst_mid.dat_wr", cbus_dat_wr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid.no_resp", resp_pulses - b_resp, 0);
    do_req("after_rst", 2'b10, 12'h305, 32'h0, 1, 0);

    for (int i = 0; i < 80; i++) begin
      logic [1:0]  op;
      logic [11:0] a;
      logic [31:0] wd;
      logic        rde, wre;
      op  = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      a   = addrs[$urandom_range(0, 7)];
      wd  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rde = 1'($urandom);
      wre = 1'($urandom);
      if (op != 2'b01 && wd == 0) wre = 0;
      lat_cfg = $urandom_range(0, 3);
      noack   = ($urandom_range(0, 9) == 0);
      preset(a, $urandom);
      do_req($sformatf("rand%0d", i), op, a, wd, rde, wre);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
